fpnew_operand_prenorm: RTL and testbench
========================================

// Module: fpnew_operand_prenorm
// PURPOSE
// - Sits directly downstream of the operand classifier and upstream of the FMA/DIVSQRT datapath.
// - Takes raw operands and their fp_info_t classification, and emits per operand:
//   - the sign,
//   - an unbiased signed exponent,
//   - a mantissa with an explicit leading one.
// - Subnormal operands are normalized with a leading-zero count.
// - Elastic valid/ready pipeline with a configurable number of register stages.
// PARAMETERS
// - FpFormat     fp_format_e'(2) (FP16)  operand format; sets EXP_BITS, MAN_BITS, BIAS
// - NumOperands  1                       operands processed in lockstep
// - NumPipeRegs  1                       register stages, 0..2; 0 = combinational pass
// - TagWidth     4                       width of the sideband tag carried with each transaction
// PORTS
// - clk_i       in   1                          clock
// - rst_ni      in   1                          asynchronous active-low reset
// - flush_i     in   1                          synchronous kill of all in-flight transactions
// - operands_i  in   NumOperands*WIDTH          raw operands
// - info_i      in   NumOperands*fp_info_t      classifier output for operands_i
// - tag_i       in   TagWidth                   sideband tag
// - valid_i     in   1                          input transaction valid
// - ready_o     out  1                          block accepts input
// - sign_o      out  NumOperands                operand signs
// - exp_o       out  NumOperands*(EXP_BITS+2)   signed unbiased exponents
// - mant_o      out  NumOperands*(MAN_BITS+1)   mantissas, MSB = explicit leading one
// - info_o      out  NumOperands*fp_info_t      classification, updated per CONFIGURATION
// - tag_o       out  TagWidth                   tag_i, delayed with its transaction
// - valid_o     out  1                          output valid
// - ready_i     in   1                          downstream accepts output
// BEHAVIOUR
// - Per-operand arithmetic, computed in the input stage:
//   - normal:    exp = exponent - BIAS; mant = {1, mantissa}.
//   - subnormal: lz = leading zeros of mantissa (MAN_BITS wide); mant = mantissa << (lz+1),
//     where the top bit is the leading one; exp = 1 - BIAS - (lz+1).
//   - zero:      exp = 0; mant = 0.
//   - sign is always passed through unchanged.
// - Exponent width: EXP_BITS+2 bits, signed, which covers the minimum 1-BIAS-MAN_BITS.
// - Handshake:
//   - A transfer occurs on a stage when valid && ready are high on the same clock edge.
//   - Stage ready = !valid_q || downstream ready.
//   - ready_o is the first stage's ready.
//   - While a stage holds a valid transaction and its downstream ready is low, that stage's
//     data is held stable.
//   - Transactions stay in order; no transaction is lost or duplicated.
// - Latency: NumPipeRegs cycles when there is no backpressure. Throughput is 1 per cycle.
// - flush_i: clears every stage valid_q on the next edge. Data registers are don't-care.
//   If flush_i is high in the same cycle as an input handshake, that input is dropped.
// - NumPipeRegs=0: outputs are combinational from the inputs; ready_o = ready_i;
//   flush_i has no effect.
// - Reset (asynchronous, any time, including mid-transaction):
//   - all valid_q = 0, so valid_o = 0;
//   - ready_o = 1 on the first cycle after deassertion;
//   - data registers reset to 0, so sign_o, exp_o, mant_o, info_o and tag_o read 0.
// - info_i.is_nan and info_i.is_inf are passed through unmodified. Mantissa and exponent for
//   these classes are don't-care.
// CONFIGURATION
// - Macro FPNEW_PRENORM_DAZ_EN (denormals-are-zero).
// - Defined:
//   - subnormal operands take the zero path: exp = 0, mant = 0;
//   - info_o.is_zero = 1 and info_o.is_subnormal = 0; sign is kept;
//   - no LZC is instantiated.
// - Not defined: subnormals are normalized as in BEHAVIOUR; info_o = info_i.
// STRUCTURE
// - fpnew_pkg supplies: fp_format_e, fp_info_t, exp_bits(), man_bits(), bias().
//   Add to fpnew_pkg a typedef prenorm_op_t {sign, exp, mant}, parameterized by format width.
// - Sub-module fpnew_prenorm_lzc: leading-zero counter of MAN_BITS width, with output
//   width $clog2(MAN_BITS), one instance per operand. It is absent under FPNEW_PRENORM_DAZ_EN.
// - The pipeline stage is a generate loop of valid/ready register slices in this module.
// TESTING
// Default configuration for all scenarios: FP16 (BIAS=15), NumOperands=1, NumPipeRegs=1.
// 1. 0x3C00 (normal) -> sign 0, exp 0, mant 0x400, valid_o one cycle after handshake.
//    0xC000 -> sign 1, exp 1, mant 0x400.
// 2. 0x0001 (subnormal) -> exp -24, mant 0x400.
//    0x0200 -> exp -15, mant 0x400.
//    Under FPNEW_PRENORM_DAZ_EN, 0x0001 -> exp 0, mant 0, is_zero 1, is_subnormal 0.
// 3. 0x8000 (negative zero) -> sign 1, exp 0, mant 0, is_zero 1.
// 4. NumPipeRegs=2: push tags 1,2,3 back-to-back with ready_i low for 3 cycles
//    -> ready_o drops once both stages are full, outputs stay stable,
//    then tags 1,2,3 appear in order with no loss.
// 5. Assert flush_i with 2 transactions in flight -> valid_o = 0 the next cycle,
//    and neither transaction appears later.
// 6. Pull rst_ni low mid-stall -> valid_o = 0 and all outputs 0 immediately (no clock edge);
//    ready_o = 1 after release.

Source files
------------

// File: rtl/fpnew_pkg.sv
// fpnew_pkg: floating-point formats, classifier info and the prenormalized operand type.
package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  localparam int unsigned MAX_EXP_BITS = 11;
  localparam int unsigned MAX_MAN_BITS = 52;

  // Sized for the widest format; narrower formats occupy the low bits of exp and mant.
  typedef struct packed {
    logic                          sign;
    logic signed [MAX_EXP_BITS+1:0] exp;
    logic [MAX_MAN_BITS:0]          mant;
  } prenorm_op_t;

  function automatic int unsigned exp_bits(fp_format_e f);
    return f == FP64 ? 11 : (f == FP32 || f == FP16ALT) ? 8 : 5;
  endfunction

  function automatic int unsigned man_bits(fp_format_e f);
    return f == FP64 ? 52 : f == FP32 ? 23 : f == FP16 ? 10 : f == FP16ALT ? 7 : 2;
  endfunction

  function automatic int unsigned bias(fp_format_e f);
    return (2 ** (exp_bits(f) - 1)) - 1;
  endfunction
endpackage

// File: rtl/fpnew_prenorm_lzc.sv
// fpnew_prenorm_lzc: leading-zero count of a WIDTH-bit vector; an all-zero input reads WIDTH-1.
module fpnew_prenorm_lzc #(
  parameter  int unsigned WIDTH = 10,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o
);
  always_comb begin
    cnt_o = CNT_W'(WIDTH - 1);
    for (int unsigned i = 0; i < WIDTH; i++) cnt_o = in_i[i] ? CNT_W'(WIDTH - 1 - i) : cnt_o;
  end
endmodule

// File: rtl/fpnew_operand_prenorm.sv
// fpnew_operand_prenorm: splits classified operands into sign, unbiased exponent and explicit-one mantissa.
// Define FPNEW_PRENORM_DAZ_EN to treat subnormal operands as zero instead of normalizing them.
module fpnew_operand_prenorm
  import fpnew_pkg::*;
#(
  parameter  fp_format_e  FpFormat    = fp_format_e'(2),
  parameter  int unsigned NumOperands = 1,
  parameter  int unsigned NumPipeRegs = 1,
  parameter  int unsigned TagWidth    = 4,
  localparam int unsigned EXP_BITS    = exp_bits(FpFormat),
  localparam int unsigned MAN_BITS    = man_bits(FpFormat),
  localparam int unsigned WIDTH       = 1 + EXP_BITS + MAN_BITS
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NumOperands*WIDTH-1:0]         operands_i,
  input  fp_info_t [NumOperands-1:0]           info_i,
  input  logic [TagWidth-1:0]                  tag_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output logic [NumOperands-1:0]               sign_o,
  output logic [NumOperands*(EXP_BITS+2)-1:0]  exp_o,
  output logic [NumOperands*(MAN_BITS+1)-1:0]  mant_o,
  output fp_info_t [NumOperands-1:0]           info_o,
  output logic [TagWidth-1:0]                  tag_o,
  output logic                                 valid_o,
  input  logic                                 ready_i
);
  localparam int unsigned BIAS = bias(FpFormat);
  localparam int unsigned EW   = EXP_BITS + 2;
  localparam int unsigned MW   = MAN_BITS + 1;
  localparam int unsigned PW   = TagWidth + NumOperands * ($bits(fp_info_t) + MW + EW + 1);

  logic [NumOperands-1:0]          op_sign;
  logic [NumOperands-1:0][EW-1:0]  op_exp;
  logic [NumOperands-1:0][MW-1:0]  op_mant;
  fp_info_t [NumOperands-1:0]      op_info;

  for (genvar k = 0; k < NumOperands; k++) begin : g_op
    logic [EXP_BITS-1:0] e;
    logic [MAN_BITS-1:0] m;
    logic [EW-1:0]       norm_exp, sub_exp;
    logic [MW-1:0]       sub_mant;
    assign {op_sign[k], e, m} = operands_i[k*WIDTH +: WIDTH];
    assign norm_exp = EW'(e) - EW'(BIAS);
`ifdef FPNEW_PRENORM_DAZ_EN
    assign sub_exp    = '0;
    assign sub_mant   = '0;
    assign op_info[k] = {info_i[k].is_normal, 1'b0, info_i[k].is_zero | info_i[k].is_subnormal,
                         info_i[k][4:0]};
`else
    logic [$clog2(MAN_BITS)-1:0] lz;
    fpnew_prenorm_lzc #(.WIDTH(MAN_BITS)) i_lzc (.in_i(m), .cnt_o(lz));
    // 1 - BIAS - (lz + 1) collapses to -BIAS - lz
    assign sub_exp    = EW'(0) - EW'(BIAS) - EW'(lz);
    assign sub_mant   = MW'(m) << lz << 1;
    assign op_info[k] = info_i[k];
`endif
    assign op_exp[k]  = info_i[k].is_zero ? '0 : info_i[k].is_subnormal ? sub_exp : norm_exp;
    assign op_mant[k] = info_i[k].is_zero ? '0 : info_i[k].is_subnormal ? sub_mant : {1'b1, m};
  end

  logic [PW-1:0] stage_data  [NumPipeRegs+1];
  logic          stage_valid [NumPipeRegs+1];
  logic          stage_ready [NumPipeRegs+1];

  assign stage_data[0]            = {tag_i, op_info, op_mant, op_exp, op_sign};
  assign stage_valid[0]           = valid_i;
  assign stage_ready[NumPipeRegs] = ready_i;

  for (genvar i = 0; i < NumPipeRegs; i++) begin : g_pipe
    logic          valid_q, valid_d;
    logic [PW-1:0] data_q;
    assign stage_ready[i] = !valid_q || stage_ready[i+1];
    assign valid_d        = flush_i ? 1'b0 : stage_ready[i] ? stage_valid[i] : valid_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        if (stage_valid[i] && stage_ready[i]) data_q <= stage_data[i];
      end
    end
    assign stage_valid[i+1] = valid_q;
    assign stage_data[i+1]  = data_q;
  end

  assign ready_o = stage_ready[0];
  assign valid_o = stage_valid[NumPipeRegs];
  assign {tag_o, info_o, mant_o, exp_o, sign_o} = stage_data[NumPipeRegs];
endmodule

// File: tb/tb_fpnew_operand_prenorm.sv
// tb_fpnew_operand_prenorm: scoreboard bench driving an FP16 NumPipeRegs=1 and a NumPipeRegs=2 instance.
module tb_fpnew_operand_prenorm;
  import fpnew_pkg::*;

  typedef struct packed {
    logic        s;
    logic [6:0]  e;
    logic [10:0] m;
    fp_info_t    i;
    logic [3:0]  t;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  logic [15:0] op = '0;
  fp_info_t    info = '0;
  logic [3:0]  tag = '0;
  logic        vin [2], rin [2], rout [2], vout [2], sgn [2];
  logic [6:0]  ex [2];
  logic [10:0] mn [2];
  fp_info_t    io [2];
  logic [3:0]  tg [2];
  exp_t        cur, q0[$], q1[$];
  int          n_chk = 0, n_pass = 0;

  logic [15:0] t_op [9] = '{16'h3C00, 16'hC000, 16'h0001, 16'h0200, 16'h8000,
                            16'h7BFF, 16'h0400, 16'h83FF, 16'h0011};
`ifdef FPNEW_PRENORM_DAZ_EN
  logic [6:0]  t_e [9] = '{7'h00, 7'h01, 7'h00, 7'h00, 7'h00, 7'h0F, 7'h72, 7'h00, 7'h00};
  logic [10:0] t_m [9] = '{11'h400, 11'h400, 11'h000, 11'h000, 11'h000,
                           11'h7FF, 11'h400, 11'h000, 11'h000};
`else
  logic [6:0]  t_e [9] = '{7'h00, 7'h01, 7'h68, 7'h71, 7'h00, 7'h0F, 7'h72, 7'h71, 7'h6C};
  logic [10:0] t_m [9] = '{11'h400, 11'h400, 11'h400, 11'h400, 11'h000,
                           11'h7FF, 11'h400, 11'h7FE, 11'h440};
`endif

  always #5 clk = ~clk;

  fpnew_operand_prenorm #(.NumPipeRegs(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .operands_i(op), .info_i(info), .tag_i(tag),
    .valid_i(vin[0]), .ready_o(rout[0]), .sign_o(sgn[0]), .exp_o(ex[0]), .mant_o(mn[0]),
    .info_o(io[0]), .tag_o(tg[0]), .valid_o(vout[0]), .ready_i(rin[0]));

  fpnew_operand_prenorm #(.NumPipeRegs(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .operands_i(op), .info_i(info), .tag_i(tag),
    .valid_i(vin[1]), .ready_o(rout[1]), .sign_o(sgn[1]), .exp_o(ex[1]), .mant_o(mn[1]),
    .info_o(io[1]), .tag_o(tg[1]), .valid_o(vout[1]), .ready_i(rin[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic fp_info_t cls(input logic [15:0] v);
    fp_info_t c;
    c.is_normal     = v[14:10] != 5'h00 && v[14:10] != 5'h1F;
    c.is_subnormal  = v[14:10] == 5'h00 && v[9:0] != 10'h0;
    c.is_zero       = v[14:10] == 5'h00 && v[9:0] == 10'h0;
    c.is_inf        = v[14:10] == 5'h1F && v[9:0] == 10'h0;
    c.is_nan        = v[14:10] == 5'h1F && v[9:0] != 10'h0;
    c.is_signalling = c.is_nan && !v[9];
    c.is_quiet      = c.is_nan && v[9];
    c.is_boxed      = 1'b1;
    return c;
  endfunction

  function automatic fp_info_t exp_info(input logic [15:0] v);
    fp_info_t c;
    c = cls(v);
`ifdef FPNEW_PRENORM_DAZ_EN
    c.is_zero      = c.is_zero | c.is_subnormal;
    c.is_subnormal = 1'b0;
`endif
    return c;
  endfunction

  task automatic send(input int d, input int k, input logic [3:0] t);
    int n = 0;
    op    = t_op[k];
    info  = cls(t_op[k]);
    tag   = t;
    cur.s = t_op[k][15];
    cur.e = t_e[k];
    cur.m = t_m[k];
    cur.i = exp_info(t_op[k]);
    cur.t = t;
    vin[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rout[d] && n < 20);
    check("send_ready", 32'(rout[d]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (vout[d] && rin[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) check("unexpected_valid", 32'(vout[d]), 32'd0);
          else begin
            if (d == 0) x = q0.pop_front();
            else x = q1.pop_front();
            check("out_sign", 32'(sgn[d]), 32'(x.s));
            check("out_exp", 32'(ex[d]), 32'(x.e));
            check("out_mant", 32'(mn[d]), 32'(x.m));
            check("out_info", 32'(io[d]), 32'(x.i));
            check("out_tag", 32'(tg[d]), 32'(x.t));
          end
        end
        if (vin[d] && rout[d]) begin
          if (d == 0) q0.push_back(cur);
          else q1.push_back(cur);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] hold_e;
    logic [3:0] hold_t;
    vin = '{1'b0, 1'b0};
    rin = '{1'b1, 1'b1};
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid0", 32'(vout[0]), 32'd0);
    check("rst_valid1", 32'(vout[1]), 32'd0);
    check("rst_mant0", 32'(mn[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready0", 32'(rout[0]), 32'd1);
    check("rst_ready1", 32'(rout[1]), 32'd1);

    send(0, 0, 4'h1);
    vin[0] = 1'b0;
    check("lat1_valid", 32'(vout[0]), 32'd1);
    send(1, 1, 4'h2);
    vin[1] = 1'b0;
    check("lat2_early", 32'(vout[1]), 32'd0);
    @(posedge clk);
    #1 check("lat2_valid", 32'(vout[1]), 32'd1);

    for (int k = 0; k < 9; k++) send(0, k, 4'(k));
    vin[0] = 1'b0;
    for (int k = 0; k < 9; k++) send(1, k, 4'(k + 4));
    vin[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    rin[1] = 1'b0;
    send(1, 5, 4'h1);
    send(1, 6, 4'h2);
    fork
      send(1, 8, 4'h3);
      begin
        check("bp_ready_low", 32'(rout[1]), 32'd0);
        hold_e = ex[1];
        hold_t = tg[1];
        repeat (3) @(posedge clk);
        #1;
        check("bp_valid_held", 32'(vout[1]), 32'd1);
        check("bp_tag_head", 32'(tg[1]), 32'd1);
        check("bp_tag_stable", 32'(tg[1]), 32'(hold_t));
        check("bp_exp_stable", 32'(ex[1]), 32'(hold_e));
        check("bp_ready_still_low", 32'(rout[1]), 32'd0);
        rin[1] = 1'b1;
      end
    join
    vin[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("bp_drained", 32'(q1.size()), 32'd0);

    rin[1] = 1'b0;
    send(1, 0, 4'h4);
    send(1, 1, 4'h5);
    vin[1] = 1'b0;
    check("fl_full", 32'(vout[1]), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("fl_valid", 32'(vout[1]), 32'd0);
    rin[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fl_gone", 32'(vout[1]), 32'd0);
    vin[0] = 1'b1;
    flush  = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    vin[0] = 1'b0;
    check("fl_drop_input", 32'(vout[0]), 32'd0);

    rin[0] = 1'b0;
    send(0, 1, 4'h6);
    vin[0] = 1'b0;
    check("rs_pre_valid", 32'(vout[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", 32'(vout[0]), 32'd0);
    check("rs_sign", 32'(sgn[0]), 32'd0);
    check("rs_exp", 32'(ex[0]), 32'd0);
    check("rs_mant", 32'(mn[0]), 32'd0);
    check("rs_info", 32'(io[0]), 32'd0);
    check("rs_tag", 32'(tg[0]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rs_ready", 32'(rout[0]), 32'd1);
    rin[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("end_q0", 32'(q0.size()), 32'd0);
    check("end_q1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
